// File: rtl/sequenciador.sv
// -----------------------------------------------------------------------------
// sequenciador -- program sequencer that drives the datapath controller.
//
// Holds a small program of 4-bit operands. When started, it issues the
// operands one at a time on Dados. Each operand is accompanied by an Instrucao
// pulse. Before moving on, the sequencer waits for a rising edge of the
// controller's Fim flag. A program ends at the first entry whose stop bit is
// set, or after the last entry. If Fim never rises, the run is abandoned with
// erro set.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low (also clears the program)
//   wr_en      program write strobe (honoured only while not running)
//   wr_addr    program entry index; indices >= PROF are ignored
//   wr_data    entry: [4] stop bit, [3:0] operand
//   inicio     start request, level-sampled each cycle
//   Fim        completion flag from the controller
//   Dados      operand presented to the datapath
//   Instrucao  step pulse to the controller, PULSO cycles wide
//   ocupado    high while a program runs
//   pronto     program finished normally, held until the next start
//   erro       controller did not complete a step within TIMEOUT cycles
//   passo      current (or last) step index
// -----------------------------------------------------------------------------
module sequenciador #(
  parameter int PROF    = 8,
  parameter int PULSO   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       inicio,
  input  logic       Fim,
  output logic [3:0] Dados,
  output logic       Instrucao,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] passo
);

  // The counters only need to reach their terminal value (N-1).
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int PUL_W = (PULSO > 1) ? $clog2(PULSO) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(PULSO - 1);
  localparam logic [3:0]       PTR_LAST = 4'(PROF - 1);
  localparam logic [4:0]       DEPTH    = 5'(PROF);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT,
    NEXT,
    DONE,
    ERRO
  } state_t;

  state_t           state, state_n;
  logic [3:0]       ptr, ptr_n;
  logic [PUL_W-1:0] pcnt, pcnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       dados_n;
  logic             fim_q;
  logic             fim_rise;
  logic             prog_open;
  logic             wr_ok;
  logic [4:0]       entry;

  // The array is sized for the full 4-bit address space. Entries at or above
  // PROF are never written, so they stay constant and are trimmed by synthesis.
  logic [4:0]       mem [16];

  assign entry     = mem[ptr];
  assign prog_open = (state == IDLE) || (state == DONE) || (state == ERRO);
  assign wr_ok     = wr_en && prog_open && ({1'b0, wr_addr} < DEPTH);
  // Fim is registered continuously, including during PULSE. An edge that
  // happens during the pulse is therefore already absorbed into fim_q by the
  // time WAIT starts.
  assign fim_rise  = Fim && !fim_q;
  assign passo     = ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    pcnt_n  = pcnt;
    cnt_n   = cnt;
    dados_n = Dados;
    case (state)
      IDLE, DONE, ERRO: begin
        if (inicio) begin
          state_n = SETUP;
          ptr_n   = '0;
        end
      end
      SETUP: begin
        // A stop entry ends the run without issuing a step; Dados keeps the
        // last operand that was issued.
        if (entry[4]) begin
          state_n = DONE;
        end else begin
          dados_n = entry[3:0];
          pcnt_n  = '0;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (pcnt == PUL_LAST) begin
          cnt_n   = '0;
          state_n = WAIT;
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      WAIT: begin
        // If an edge and the timeout occur in the same cycle, the edge wins.
        if (fim_rise) begin
          state_n = NEXT;
        end else if (cnt == CNT_LAST) begin
          state_n = ERRO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      NEXT: begin
        if (ptr == PTR_LAST) begin
          state_n = DONE;
        end else begin
          ptr_n   = ptr + 4'd1;
          state_n = SETUP;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they line up exactly
  // with the state they describe, with no extra cycle of delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      pcnt      <= '0;
      cnt       <= '0;
      fim_q     <= 1'b0;
      Dados     <= '0;
      Instrucao <= 1'b0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
    end else begin
      ptr       <= ptr_n;
      pcnt      <= pcnt_n;
      cnt       <= cnt_n;
      fim_q     <= Fim;
      Dados     <= dados_n;
      Instrucao <= (state_n == PULSE);
      ocupado   <= (state_n == SETUP) || (state_n == PULSE) ||
                   (state_n == WAIT)  || (state_n == NEXT);
      pronto    <= (state_n == DONE);
      erro      <= (state_n == ERRO);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sequenciador.sv
// -----------------------------------------------------------------------------
// Testbench for sequenciador: directed program scenarios, a behavioural
// reference checked every cycle, and a controller model that answers each
// step with a Fim pulse.
// -----------------------------------------------------------------------------
module tb_sequenciador;

  localparam int PROF    = 8;
  localparam int PULSO   = 2;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;
  logic       inicio;
  logic       Fim;
  logic [3:0] Dados;
  logic       Instrucao;
  logic       ocupado;
  logic       pronto;
  logic       erro;
  logic [3:0] passo;

  sequenciador #(.PROF(PROF), .PULSO(PULSO), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inicio(inicio), .Fim(Fim), .Dados(Dados), .Instrucao(Instrucao),
    .ocupado(ocupado), .pronto(pronto), .erro(erro), .passo(passo)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // The reference tracks a run as a timeline. m_t counts the cycles since the
  // current step was picked up: cycle 0 is the read of the entry, cycles
  // 1..PULSO carry the pulse, and every later cycle is a wait cycle.
  logic [4:0] m_mem [16];
  logic       m_busy, m_ins, m_pronto, m_erro, m_adv, m_fim_prev, m_edge;
  logic [3:0] m_dados, m_ptr;
  int         m_t;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        foreach (m_mem[i]) m_mem[i] = '0;
        m_busy = 0; m_ins = 0; m_pronto = 0; m_erro = 0; m_adv = 0;
        m_fim_prev = 0; m_edge = 0; m_dados = '0; m_ptr = '0; m_t = 0;
      end else begin
        m_edge     = Fim && !m_fim_prev;
        m_fim_prev = Fim;
        if (wr_en && !m_busy && int'(wr_addr) < PROF) m_mem[wr_addr] = wr_data;
        if (!m_busy) begin
          if (inicio) begin
            m_busy = 1; m_pronto = 0; m_erro = 0; m_ptr = '0; m_t = 0;
          end
        end else if (m_adv) begin
          m_adv = 0;
          if (int'(m_ptr) == PROF - 1) begin
            m_busy = 0; m_pronto = 1;
          end else begin
            m_ptr = m_ptr + 4'd1; m_t = 0;
          end
        end else begin
          m_t++;
          if (m_t == 1) begin
            if (m_mem[m_ptr][4]) begin
              m_busy = 0; m_pronto = 1;
            end else begin
              m_dados = m_mem[m_ptr][3:0]; m_ins = 1;
            end
          end else if (m_t == 1 + PULSO) begin
            m_ins = 0;
          end else if (m_t > 1 + PULSO) begin
            if (m_edge) m_adv = 1;
            else if (m_t - 1 - PULSO == TIMEOUT) begin
              m_busy = 0; m_erro = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + pulse log ----------------
  int         n_pulses = 0;
  logic [3:0] seen [$];
  logic       ins_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      check("ocupado",   int'(ocupado),   int'(m_busy));
      check("Instrucao", int'(Instrucao), int'(m_ins));
      check("Dados",     int'(Dados),     int'(m_dados));
      check("passo",     int'(passo),     int'(m_ptr));
      check("pronto",    int'(pronto),    int'(m_pronto));
      check("erro",      int'(erro),      int'(m_erro));
      if (Instrucao && !ins_prev) begin
        n_pulses++;
        seen.push_back(Dados);
      end
      ins_prev = Instrucao;
    end
  end

  // ---------------- controller model ----------------
  // mode 0: answer each pulse (up to resp_limit pulses past resp_base) with a
  //         one-cycle Fim, 3 cycles after the pulse falls
  // mode 1: silent; mode 2: Fim held high; mode 3: Fim = fim_man
  int   fim_mode   = 0;
  logic fim_man    = 1'b0;
  int   resp_base  = 0;
  int   resp_limit = 1000;

  initial begin
    int   cd;
    logic ip;
    Fim = 1'b0; cd = 0; ip = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        cd = 0; Fim = 1'b0;
      end else begin
        case (fim_mode)
          0: begin
            Fim = 1'b0;
            if (ip && !Instrucao && (n_pulses - resp_base) <= resp_limit) cd = 3;
            else if (cd != 0) begin
              cd--;
              if (cd == 0) Fim = 1'b1;
            end
          end
          2:       Fim = 1'b1;
          3:       Fim = fim_man;
          default: Fim = 1'b0;
        endcase
      end
      ip = Instrucao;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (ocupado && n < budget) begin tick(); n++; end
    check(name, int'(ocupado), 0);
  endtask

  task automatic wait_pulse_done(input string name, input int target, input int budget);
    int n = 0;
    while (!(n_pulses >= target && !Instrucao) && n < budget) begin tick(); n++; end
    check(name, int'(n_pulses >= target && !Instrucao), 1);
  endtask

  function automatic int seen_at(input int idx);
    return (idx < seen.size()) ? int'(seen[idx]) : -1;
  endfunction

  logic [3:0] prog8 [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int base, sb, k;
    prog8 = '{4'hA, 4'h1, 4'h7, 4'hF, 4'h0, 4'h8, 4'h4, 4'hC};
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; inicio = 1'b0;
    repeat (3) tick();
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_Dados",   int'(Dados),   0);
    check("rst_passo",   int'(passo),   0);
    check("rst_pronto",  int'(pronto),  0);
    rst = 1'b1;
    tick();

    // Two-step program with stop at entry 2
    wr(4'd0, 5'h03); wr(4'd1, 5'h05); wr(4'd2, 5'h10);
    base = n_pulses; sb = seen.size();
    start();
    check("t1_setup_ins",  int'(Instrucao), 0);
    check("t1_setup_busy", int'(ocupado),   1);
    tick();
    check("t1_lat2_ins",   int'(Instrucao), 1);
    check("t1_dados0",     int'(Dados),     3);
    wait_idle("t1_idle", 100);
    check("t1_pulses", n_pulses - base, 2);
    check("t1_op1",    seen_at(sb + 1), 5);
    check("t1_pronto", int'(pronto), 1);
    check("t1_passo",  int'(passo),  2);
    check("t1_erro",   int'(erro),   0);

    // Controller stops answering after step 0 -> timeout at step 1
    resp_base = n_pulses; resp_limit = 1;
    base = n_pulses;
    start();
    wait_pulse_done("t2_step1_pulse", base + 2, 40);
    k = 0;
    while (!erro && k < 400) begin tick(); k++; end
    check("t2_wait_cycles", k, 255);
    check("t2_erro",   int'(erro),    1);
    check("t2_passo",  int'(passo),   1);
    check("t2_Dados",  int'(Dados),   5);
    check("t2_busy",   int'(ocupado), 0);
    check("t2_pronto", int'(pronto),  0);
    resp_limit = 1000;
    start();
    check("t2_re_erro",  int'(erro),    0);
    check("t2_re_passo", int'(passo),   0);
    check("t2_re_busy",  int'(ocupado), 1);
    wait_idle("t2_re_idle", 100);
    check("t2_re_pronto", int'(pronto), 1);

    // Full 8-entry program, then an out-of-range write that must touch nothing
    for (int i = 0; i < 8; i++) wr(4'(i), {1'b0, prog8[i]});
    wr(4'd9, 5'h1A);
    base = n_pulses; sb = seen.size();
    start();
    wait_idle("t3_idle", 200);
    check("t3_pulses", n_pulses - base, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_op%0d", i), seen_at(sb + i), int'(prog8[i]));
    check("t3_pronto", int'(pronto), 1);
    check("t3_passo",  int'(passo),  7);

    // Fim held high: no edge ever -> timeout at step 0
    wr(4'd0, 5'h03); wr(4'd1, 5'h05); wr(4'd2, 5'h10);
    fim_mode = 2;
    repeat (3) tick();
    base = n_pulses;
    start();
    wait_idle("t4_idle", 400);
    check("t4_erro",   int'(erro),  1);
    check("t4_passo",  int'(passo), 0);
    check("t4_Dados",  int'(Dados), 3);
    check("t4_pulses", n_pulses - base, 1);
    // Rerun: toggle Fim low->high in WAIT, then hand back to the responder
    fim_man = 1'b1; fim_mode = 3;
    tick();
    base = n_pulses; sb = seen.size();
    start();
    wait_pulse_done("t4_step0_pulse", base + 1, 20);
    fim_man = 1'b0;
    repeat (2) tick();
    fim_man = 1'b1;
    repeat (3) tick();
    fim_mode = 0;
    wait_idle("t4_re_idle", 100);
    check("t4_re_pulses", n_pulses - base, 2);
    check("t4_re_op1",    seen_at(sb + 1), 5);
    check("t4_re_pronto", int'(pronto), 1);
    check("t4_re_passo",  int'(passo),  2);

    // Write during a run is ignored
    start();
    repeat (2) tick();
    wr(4'd0, 5'h1F);
    wait_idle("t6_idle", 100);
    base = n_pulses; sb = seen.size();
    start();
    wait_idle("t6_re_idle", 100);
    check("t6_pulses", n_pulses - base, 2);
    check("t6_op0",    seen_at(sb), 3);

    // Reset during WAIT of step 1 clears outputs and memory
    base = n_pulses;
    start();
    wait_pulse_done("t5_step1_pulse", base + 2, 40);
    rst = 1'b0;
    #1;
    check("t5_rst_busy",  int'(ocupado), 0);
    check("t5_rst_Dados", int'(Dados),   0);
    check("t5_rst_passo", int'(passo),   0);
    tick();
    rst = 1'b1;
    tick();
    base = n_pulses; sb = seen.size();
    start();
    wait_pulse_done("t5_re_pulse", base + 1, 20);
    check("t5_re_op0", seen_at(sb), 0);
    wait_idle("t5_re_idle", 200);
    check("t5_re_pulses", n_pulses - base, 8);
    check("t5_re_passo",  int'(passo), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
